ex_regincr_reg_incr_pipe: RTL and testbench

//   Parametrised, elastic, multi-stage register-incrementer. Each of NSTAGES

---
 rtl/ex_regincr_pkg.sv | 26 ++
 rtl/ex_regincr_reg_incr_stage.sv | 44 ++++
 rtl/ex_regincr_reg_incr_pipe.sv | 84 ++++++++
 tb/tb_ex_regincr_reg_incr_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_regincr_pkg.sv
// Shared constants and the per-stage increment function for the
// multi-stage register-incrementer pipeline.
package ex_regincr_pkg;

   localparam int MAX_NBITS   = 64;
   localparam int DEF_NBITS   = 8;
   localparam int DEF_NSTAGES = 3;
   localparam int DEF_INCR    = 1;

   typedef logic [MAX_NBITS-1:0] word_t;

   // Adds incr to x within an nbits-wide word, wrapping or clamping at all-ones.
   // Operands must already be zero-extended from nbits.
   function automatic word_t incr_sat(input word_t x, input word_t incr,
                                      input int nbits, input bit sat);
      logic [MAX_NBITS:0] sum;
      logic [MAX_NBITS:0] max_v;
      max_v = ((MAX_NBITS+1)'(1) << nbits) - (MAX_NBITS+1)'(1);
      sum   = {1'b0, x} + {1'b0, incr};
      if (sat && (sum > max_v)) begin
         sum = max_v;
      end
      return word_t'(sum & max_v);
   endfunction

endpackage

// File: rtl/ex_regincr_reg_incr_stage.sv
// One elastic pipeline stage: a valid/data register that loads the
// incremented upstream message whenever this slot is free or draining.
module ex_regincr_reg_incr_stage
   import ex_regincr_pkg::*;
#(
   parameter int          NBITS    = DEF_NBITS,
   parameter int unsigned INCR     = DEF_INCR,
   parameter bit          SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             prev_val,
   input  logic [NBITS-1:0] prev_data,
   input  logic             next_rdy,
   output logic             rdy,
   output logic             val,
   output logic [NBITS-1:0] data
);

   localparam word_t INCR_W = word_t'(NBITS'(INCR));

   logic [NBITS-1:0] data_nxt;

   // A slot can take a new message if it is empty or its occupant leaves now.
   assign rdy      = !val || next_rdy;
   assign data_nxt = NBITS'(incr_sat(word_t'(prev_data), INCR_W, NBITS, SATURATE));

   // NOTE: non-blocking updates make every stage capture its neighbour's pre-edge value.
   always_ff @(posedge clk) begin
      if (reset) begin
         val <= 1'b0;
      end else if (rdy) begin
         val <= prev_val;
      end
   end

   // NOTE: data carries no reset; val alone decides whether it is meaningful.
   always_ff @(posedge clk) begin
      if (rdy) begin
         data <= data_nxt;
      end
   end

endmodule

// File: rtl/ex_regincr_reg_incr_pipe.sv
// Parametrised elastic register-incrementer: NSTAGES chained stages with
// val/rdy handshakes on both ends and an in-flight message counter.
module ex_regincr_reg_incr_pipe
   import ex_regincr_pkg::*;
#(
   parameter int          NBITS    = DEF_NBITS,
   parameter int          NSTAGES  = DEF_NSTAGES,
   parameter int unsigned INCR     = DEF_INCR,
   parameter bit          SATURATE = 1'b0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in_val,
   output logic                               in_rdy,
   input  logic [NBITS-1:0]                   in_msg,
   output logic                               out_val,
   input  logic                               out_rdy,
   output logic [NBITS-1:0]                   out_msg,
   output logic [$clog2(NSTAGES+1)-1:0]       count
);

   localparam int CW = $clog2(NSTAGES+1);

   logic in_fire;
   logic out_fire;

   // Each generate scope owns its own handshake nets, so the ready chain
   // is a straight combinational path rather than a self-referencing vector.
   for (genvar i = 1; i <= NSTAGES; i++) begin : stage_g
      logic             prev_val;
      logic [NBITS-1:0] prev_data;
      logic             next_rdy;
      logic             rdy;
      logic             val;
      logic [NBITS-1:0] data;

      if (i == 1) begin : first_g
         assign prev_val  = in_val;
         assign prev_data = in_msg;
      end else begin : chain_g
         assign prev_val  = stage_g[i-1].val;
         assign prev_data = stage_g[i-1].data;
      end

      if (i == NSTAGES) begin : last_g
         assign next_rdy = out_rdy;
      end else begin : mid_g
         assign next_rdy = stage_g[i+1].rdy;
      end

      ex_regincr_reg_incr_stage #(
         .NBITS    (NBITS),
         .INCR     (INCR),
         .SATURATE (SATURATE)
      ) u_stage (
         .clk       (clk),
         .reset     (reset),
         .prev_val  (prev_val),
         .prev_data (prev_data),
         .next_rdy  (next_rdy),
         .rdy       (rdy),
         .val       (val),
         .data      (data)
      );
   end

   assign in_rdy   = stage_g[1].rdy;
   assign out_val  = stage_g[NSTAGES].val;
   assign out_msg  = stage_g[NSTAGES].data;
   assign in_fire  = in_val && in_rdy;
   assign out_fire = out_val && out_rdy;

   // Simultaneous push and pop leave the occupancy unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (in_fire && !out_fire) begin
         count <= count + CW'(1);
      end else if (out_fire && !in_fire) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_ex_regincr_reg_incr_pipe.sv
// Self-checking bench: three pipe variants share one stimulus stream and are
// compared every cycle against a message-list model of the elastic pipe.
module tb_ex_regincr_reg_incr_pipe;

   localparam int N = 3;

   typedef struct {
      logic [7:0] msg;
      int         pos;
   } ent_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_val = 1'b0;
   logic [7:0] in_msg = 8'h00;
   logic       out_rdy = 1'b0;

   logic       in_rdy_m, in_rdy_s, in_rdy_i;
   logic       out_val_m, out_val_s, out_val_i;
   logic [7:0] out_msg_m, out_msg_s, out_msg_i;
   logic [1:0] count_m, count_s, count_i;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   ent_t       q[$];
   logic [7:0] obs_m[$];
   logic [7:0] obs_s[$];
   logic [7:0] obs_i[$];
   int         obs_cyc[$];

   logic       last_in_rdy, last_out_val, last_in_fire;
   logic [1:0] last_count;
   logic [7:0] last_out_msg;

   always #5 clk = ~clk;

   ex_regincr_reg_incr_pipe #(.NBITS(8), .NSTAGES(N), .INCR(1), .SATURATE(1'b0)) u_main (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_m), .in_msg(in_msg),
      .out_val(out_val_m), .out_rdy(out_rdy), .out_msg(out_msg_m), .count(count_m));

   ex_regincr_reg_incr_pipe #(.NBITS(8), .NSTAGES(N), .INCR(1), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_s), .in_msg(in_msg),
      .out_val(out_val_s), .out_rdy(out_rdy), .out_msg(out_msg_s), .count(count_s));

   ex_regincr_reg_incr_pipe #(.NBITS(8), .NSTAGES(N), .INCR(5), .SATURATE(1'b0)) u_inc5 (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_i), .in_msg(in_msg),
      .out_val(out_val_i), .out_rdy(out_rdy), .out_msg(out_msg_i), .count(count_i));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Whole-pipe result: kind 0 wraps +3, kind 1 clamps +3 at 0xff, kind 2 wraps +15.
   function automatic logic [7:0] model_out(input int kind, input logic [7:0] m);
      int s;
      s = int'(m) + ((kind == 2) ? 15 : 3);
      if (kind == 1 && s > 255) return 8'hff;
      return 8'(s % 256);
   endfunction

   function automatic logic [7:0] obs_at(input int which, input int i);
      if (which == 0) return (obs_m.size() > i) ? obs_m[i] : 8'hxx;
      if (which == 1) return (obs_s.size() > i) ? obs_s[i] : 8'hxx;
      return (obs_i.size() > i) ? obs_i[i] : 8'hxx;
   endfunction

   function automatic int cyc_at(input int i);
      return (obs_cyc.size() > i) ? obs_cyc[i] : -1;
   endfunction

   task automatic clear_obs();
      obs_m.delete();
      obs_s.delete();
      obs_i.delete();
      obs_cyc.delete();
   endtask

   // One clock cycle: drive, compare against the model, then advance the model.
   task automatic cycle(input logic v, input logic [7:0] m, input logic r,
                        input logic rst, input bit chk);
      logic exp_in_rdy, exp_out_val, in_fire, out_fire;
      int   prev;
      @(negedge clk);
      in_val  = v;
      in_msg  = m;
      out_rdy = r;
      reset   = rst;
      #1;
      exp_in_rdy  = (q.size() < N) || r;
      exp_out_val = (q.size() > 0) && (q[0].pos == N);
      if (chk) begin
         check("in_rdy", 32'(in_rdy_m), 32'(exp_in_rdy));
         check("out_val", 32'(out_val_m), 32'(exp_out_val));
         check("count", 32'(count_m), 32'(q.size()));
         check("sat_in_rdy", 32'(in_rdy_s), 32'(exp_in_rdy));
         check("inc5_out_val", 32'(out_val_i), 32'(exp_out_val));
         check("inc5_count", 32'(count_i), 32'(q.size()));
         if (exp_out_val) begin
            check("out_msg", 32'(out_msg_m), 32'(model_out(0, q[0].msg)));
            check("sat_out_msg", 32'(out_msg_s), 32'(model_out(1, q[0].msg)));
            check("inc5_out_msg", 32'(out_msg_i), 32'(model_out(2, q[0].msg)));
         end
      end
      last_in_rdy  = in_rdy_m;
      last_out_val = out_val_m;
      last_count   = count_m;
      last_out_msg = out_msg_m;
      in_fire      = v && exp_in_rdy && !rst;
      out_fire     = exp_out_val && r && !rst;
      last_in_fire = in_fire;
      if (out_fire) begin
         obs_m.push_back(out_msg_m);
         obs_s.push_back(out_msg_s);
         obs_i.push_back(out_msg_i);
         obs_cyc.push_back(cyc);
      end
      @(posedge clk);
      if (rst) begin
         q.delete();
      end else begin
         if (out_fire) void'(q.pop_front());
         prev = N + 1;
         foreach (q[i]) begin
            q[i].pos = (q[i].pos + 1 < prev - 1) ? q[i].pos + 1 : prev - 1;
            prev = q[i].pos;
         end
         if (in_fire) q.push_back('{msg: m, pos: 1});
      end
      cyc++;
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   initial begin
      int c0;
      int k;
      int acc;

      // Reset held two cycles.
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("reset_in_rdy", 32'(last_in_rdy), 32'd1);
      check("reset_count", 32'(last_count), 32'd0);
      check("reset_out_val", 32'(last_out_val), 32'd0);

      // Single message latency.
      clear_obs();
      c0 = cyc;
      cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 10 && obs_m.size() == 0; i++) drain(1);
      check("single_msg", 32'(obs_at(0, 0)), 32'h03);
      check("single_latency", 32'(cyc_at(0) - c0), 32'd3);

      // Back-to-back pair.
      clear_obs();
      cycle(1'b1, 8'h13, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 8'h27, 1'b1, 1'b0, 1'b1);
      drain(5);
      check("b2b_first", 32'(obs_at(0, 0)), 32'h16);
      check("b2b_second", 32'(obs_at(0, 1)), 32'h2a);
      check("b2b_consecutive", 32'(cyc_at(1) - cyc_at(0)), 32'd1);

      // Backpressure: four offered, three accepted, then drain in order.
      clear_obs();
      k = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b1);
         if (last_in_fire) k++;
         if (i >= 3) check("stall_out_msg_stable", 32'(last_out_msg), 32'h43);
      end
      check("stall_accepted", 32'(k), 32'd3);
      check("stall_in_rdy", 32'(last_in_rdy), 32'd0);
      check("stall_count", 32'(last_count), 32'd3);
      cycle(1'b1, 8'(8'h40 + k), 1'b1, 1'b0, 1'b1);
      check("full_pass_through_in_rdy", 32'(last_in_rdy), 32'd1);
      drain(6);
      for (int i = 0; i < 4; i++) check("drain_order", 32'(obs_at(0, i)), 32'(8'h43 + i));

      // Wrap, saturate, and larger increment.
      clear_obs();
      cycle(1'b1, 8'hfe, 1'b1, 1'b0, 1'b1);
      cycle(1'b1, 8'h10, 1'b1, 1'b0, 1'b1);
      drain(6);
      check("wrap_fe", 32'(obs_at(0, 0)), 32'h01);
      check("sat_fe", 32'(obs_at(1, 0)), 32'hff);
      check("sat_10", 32'(obs_at(1, 1)), 32'h13);
      check("inc5_fe", 32'(obs_at(2, 0)), 32'h0d);
      check("inc5_10", 32'(obs_at(2, 1)), 32'h1f);

      // Reset with two messages in flight flushes them.
      clear_obs();
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      check("flush_count", 32'(last_count), 32'd0);
      check("flush_out_val", 32'(last_out_val), 32'd0);
      drain(6);
      check("flush_nothing_emitted", 32'(obs_m.size()), 32'd0);

      // Random traffic with occasional reset.
      clear_obs();
      acc = 0;
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) < 7,
               $urandom_range(0, 199) == 0, 1'b1);
         if (last_in_fire) acc++;
      end
      drain(8);
      check("random_traffic_seen", 32'(acc > 100), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
